// File: rtl/hw_alu_seq_pkg.sv
// Shared definitions for the registered ALU: opcodes, FSM encoding and the
// add/sub carry/overflow helper.
package hw_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_ACC = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Returns {carry_or_borrow, overflow}. For subtraction the adder sees ~b,
    // so the borrow is the inverted carry-out and b's sign is inverted.
    function automatic logic [1:0] addsub_flags(input logic a_msb, input logic b_msb,
                                                input logic r_msb, input logic cout,
                                                input logic is_sub);
        logic b_eff;
        b_eff = is_sub ? ~b_msb : b_msb;
        return {(is_sub ? ~cout : cout), ((a_msb == b_eff) && (r_msb != a_msb))};
    endfunction

endpackage

// File: rtl/hw_alu_seq_if.sv
// Command/result handshake bundle between a command source (master) and the ALU (slave).
interface hw_alu_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, sel, din0, din1, acc_clr, out_ready,
        input  in_ready, out_valid, dout, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, sel, din0, din1, acc_clr, out_ready,
        output in_ready, out_valid, dout, flag_z, flag_c, flag_v
    );
endinterface

// File: rtl/hw_alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH bits total,
// with bit 0 folded into the start cycle so done pulses WIDTH-1 cycles after start.
module hw_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand  <= {{WIDTH{1'b0}}, a} << 1;
                mplier <= b >> 1;
                cnt    <= CW'(WIDTH - 1);
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/hw_alu_seq.sv
// Registered ALU with valid/ready handshakes, accumulator, status flags and an
// iterative multiplier behind a three-state handshake FSM.
module hw_alu_seq
    import hw_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    hw_alu_seq_if.slave  bus
);
    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_base;
    logic [WIDTH-1:0]   dout_r;
    logic               z_r, c_r, v_r, out_valid_r;
    logic [WIDTH-1:0]   res;
    logic               res_c, res_v;
    logic [WIDTH:0]     sum_add, sum_sub, sum_acc;
    logic               accept, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign bus.in_ready  = (state == S_IDLE) || ((state == S_HOLD) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign mul_start     = accept && (bus.sel == OP_MUL) && !mul_busy;
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.flag_z    = z_r;
    assign bus.flag_c    = c_r;
    assign bus.flag_v    = v_r;

    hw_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (bus.din0),
        .b     (bus.din1),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // A clear coinciding with an ACC makes the old accumulator read as zero.
    always_comb begin
        acc_base = bus.acc_clr ? '0 : acc;
        sum_add  = {1'b0, bus.din0} + {1'b0, bus.din1};
        sum_sub  = {1'b0, bus.din0} + {1'b0, ~bus.din1} + (WIDTH+1)'(1);
        sum_acc  = {1'b0, acc_base} + {1'b0, bus.din0};
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                res = sum_add[WIDTH-1:0];
                {res_c, res_v} = addsub_flags(bus.din0[WIDTH-1], bus.din1[WIDTH-1],
                                              sum_add[WIDTH-1], sum_add[WIDTH], 1'b0);
            end
            OP_SUB: begin
                res = sum_sub[WIDTH-1:0];
                {res_c, res_v} = addsub_flags(bus.din0[WIDTH-1], bus.din1[WIDTH-1],
                                              sum_sub[WIDTH-1], sum_sub[WIDTH], 1'b1);
            end
            OP_AND: res = bus.din0 & bus.din1;
            OP_SHR: res = {1'b0, bus.din0[WIDTH-1:1]};
            OP_OR:  res = bus.din0 | bus.din1;
            OP_XOR: res = bus.din0 ^ bus.din1;
            OP_ACC: begin
                res = sum_acc[WIDTH-1:0];
                {res_c, res_v} = addsub_flags(acc_base[WIDTH-1], bus.din0[WIDTH-1],
                                              sum_acc[WIDTH-1], sum_acc[WIDTH], 1'b0);
            end
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            dout_r      <= '0;
            z_r         <= 1'b0;
            c_r         <= 1'b0;
            v_r         <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept && (bus.sel == OP_ACC)) acc <= res;
            else if (bus.acc_clr)               acc <= '0;

            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        if (bus.sel == OP_MUL) begin
                            state       <= S_MUL;
                            out_valid_r <= 1'b0;
                        end else begin
                            state       <= S_HOLD;
                            out_valid_r <= 1'b1;
                            dout_r      <= res;
                            z_r         <= (res == '0);
                            c_r         <= res_c;
                            v_r         <= res_v;
                        end
                    end else if ((state == S_HOLD) && bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        state       <= S_HOLD;
                        out_valid_r <= 1'b1;
                        dout_r      <= mul_prod[WIDTH-1:0];
                        z_r         <= (mul_prod[WIDTH-1:0] == '0);
                        c_r         <= |mul_prod[2*WIDTH-1:WIDTH];
                        v_r         <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
